// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared constants and types for the ULA result/flag writeback stage.
//  - BITS_DEF / AW_DEF   : default datapath and register-address widths
//  - OPC_*               : op-class codes taken from OP[4:3]
//  - F_*                 : bit positions inside the {O,C,S,Z} flag vector
//  - wb_entry_t          : one queued register-file writeback {addr, data}
//  - flags_next()        : architectural flag update rule
// ---------------------------------------------------------------------------
package ula_pkg;

   localparam int unsigned BITS_DEF = 3;
   localparam int unsigned AW_DEF   = 3;
   localparam int unsigned NFLAGS   = 4;

   localparam logic [1:0] OPC_ARITH = 2'b00;
   localparam logic [1:0] OPC_SHIFT = 2'b01;

   localparam int unsigned F_O = 3;
   localparam int unsigned F_C = 2;
   localparam int unsigned F_S = 1;
   localparam int unsigned F_Z = 0;

   typedef logic [NFLAGS-1:0] flags_t;

   typedef struct packed {
      logic [AW_DEF-1:0]   addr;
      logic [BITS_DEF-1:0] data;
   } wb_entry_t;

   // Next flag value. An accepted arithmetic/shift op takes priority over a
   // concurrent clear; move/other ops leave the flags alone (but still let a
   // clear through).
   function automatic flags_t flags_next(input flags_t     cur,
                                         input logic       clr,
                                         input logic       acc,
                                         input logic [1:0] opc,
                                         input flags_t     ulaf);
      flags_t nxt;
      nxt = cur;
      if (clr) begin
         nxt = '0;
      end
      if (acc) begin
         unique case (opc)
            OPC_ARITH: nxt = ulaf;
            OPC_SHIFT: begin
               nxt      = ulaf;
               nxt[F_O] = 1'b0;   // shift/logic never reports overflow
            end
            default: ;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ula_wb_fifo.sv
// ---------------------------------------------------------------------------
// ula_wb_fifo
// Two-entry valid/ready FIFO holding pending register-file writebacks.
//  clk, rst_n      : clock, async active-low reset (drops all entries)
//  push, push_data : enqueue request and entry (ignored when full)
//  full            : both slots occupied
//  pop             : consumer takes the head entry (ignored when empty)
//  head_valid      : at least one entry queued
//  head_data       : oldest entry; held stable until popped
// ---------------------------------------------------------------------------
module ula_wb_fifo
   import ula_pkg::*;
#(
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  entry_t push_data,
   output logic   full,
   input  logic   pop,
   output logic   head_valid,
   output entry_t head_data
);

   entry_t     mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;
   logic       push_ok, pop_ok;

   assign full       = (cnt_q == 2'd2);
   assign head_valid = (cnt_q != 2'd0);
   assign head_data  = mem_q[rd_ptr_q];

   assign push_ok = push & ~full;
   assign pop_ok  = pop & head_valid;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;   // idle, or push+pop keeps occupancy
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ula_flag_writeback.sv
// ---------------------------------------------------------------------------
// ula_flag_writeback
// Stage after the ULA: keeps the architectural {O,C,S,Z} flag register,
// counts overflowing ops, and queues register-file writebacks.
//  clk, rst_n              : clock, async active-low reset
//  in_valid / in_ready     : ULA result handshake (in_ready = buffer not full)
//  in_op                   : ULA OP; class taken from in_op[4:3]
//  in_resu                 : ULA result, stored unmodified
//  in_o/in_c/in_s/in_z     : ULA flags
//  in_wb_en, in_wb_addr    : queue a writeback of in_resu to in_wb_addr
//  flag_clr                : synchronous clear of the flag register
//  wb_valid/wb_ready       : register-file write port handshake
//  wb_addr, wb_data        : head writeback entry
//  flags                   : architectural flags {O,C,S,Z}
//  ovf_cnt                 : accepted ops with in_o=1, saturating
// ---------------------------------------------------------------------------
module ula_flag_writeback
   import ula_pkg::*;
#(
   parameter int unsigned BITS = BITS_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_op,
   input  logic [BITS-1:0] in_resu,
   input  logic            in_o,
   input  logic            in_c,
   input  logic            in_s,
   input  logic            in_z,
   input  logic            in_wb_en,
   input  logic [AW-1:0]   in_wb_addr,
   input  logic            flag_clr,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [AW-1:0]   wb_addr,
   output logic [BITS-1:0] wb_data,
   output logic [3:0]      flags,
   output logic [CNTW-1:0] ovf_cnt
);

   // Entry type sized from this instance's parameters.
   typedef struct packed {
      logic [AW-1:0]   addr;
      logic [BITS-1:0] data;
   } entry_t;

   localparam logic [CNTW-1:0] OVF_MAX = '1;

   logic            accept, push, pop, full;
   logic [1:0]      opc;
   flags_t          ula_flags;
   flags_t          flags_q, flags_d;
   logic [CNTW-1:0] ovf_q, ovf_d;
   entry_t          push_entry, head_entry;

   // Only the class bits matter here.
   logic unused_op_lo;
   assign unused_op_lo = ^in_op[2:0];

   assign opc    = in_op[4:3];
   assign accept = in_valid & in_ready;
   assign push   = accept & in_wb_en;
   assign pop    = wb_valid & wb_ready;

   always_comb begin
      ula_flags      = '0;
      ula_flags[F_O] = in_o;
      ula_flags[F_C] = in_c;
      ula_flags[F_S] = in_s;
      ula_flags[F_Z] = in_z;
   end

   always_comb begin
      flags_d = flags_next(flags_q, flag_clr, accept, opc, ula_flags);
   end

   always_comb begin
      ovf_d = ovf_q;
      if (accept && in_o && (ovf_q != OVF_MAX)) begin
         ovf_d = ovf_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         ovf_q   <= '0;
      end else begin
         flags_q <= flags_d;
         ovf_q   <= ovf_d;
      end
   end

   assign push_entry.addr = in_wb_addr;
   assign push_entry.data = in_resu;

   ula_wb_fifo #(
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_entry),
      .full       (full),
      .pop        (pop),
      .head_valid (wb_valid),
      .head_data  (head_entry)
   );

   // in_ready depends only on buffer state, never on wb_ready.
   assign in_ready = ~full;
   assign wb_addr  = head_entry.addr;
   assign wb_data  = head_entry.data;
   assign flags    = flags_q;
   assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_ula_flag_writeback.sv
// ---------------------------------------------------------------------------
// tb_ula_flag_writeback
// Directed stimulus against a queue-based reference model. Two instances
// share all inputs: CNTW=8 (main) and CNTW=2 (counter saturation).
// ---------------------------------------------------------------------------
module tb_ula_flag_writeback;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [4:0] in_op;
   logic [2:0] in_resu;
   logic       in_o, in_c, in_s, in_z;
   logic       in_wb_en;
   logic [2:0] in_wb_addr;
   logic       flag_clr;
   logic       wb_ready;

   logic       in_ready, wb_valid;
   logic [2:0] wb_addr, wb_data;
   logic [3:0] flags;
   logic [7:0] ovf_cnt;

   logic       in_ready2, wb_valid2;
   logic [2:0] wb_addr2, wb_data2;
   logic [3:0] flags2;
   logic [1:0] ovf_cnt2;

   int n_checks = 0;
   int n_errors = 0;
   bit run = 1'b0;

   // Reference model state
   logic [5:0] mq[$];     // {addr, data}
   logic [3:0] m_flags;
   int         m_ovf;

   always #5 clk = ~clk;

   ula_flag_writeback #(.BITS(3), .AW(3), .CNTW(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_resu(in_resu), .in_o(in_o), .in_c(in_c), .in_s(in_s),
      .in_z(in_z), .in_wb_en(in_wb_en), .in_wb_addr(in_wb_addr),
      .flag_clr(flag_clr), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags), .ovf_cnt(ovf_cnt)
   );

   ula_flag_writeback #(.BITS(3), .AW(3), .CNTW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .in_op(in_op), .in_resu(in_resu), .in_o(in_o), .in_c(in_c), .in_s(in_s),
      .in_z(in_z), .in_wb_en(in_wb_en), .in_wb_addr(in_wb_addr),
      .flag_clr(flag_clr), .wb_valid(wb_valid2), .wb_ready(wb_ready),
      .wb_addr(wb_addr2), .wb_data(wb_data2), .flags(flags2), .ovf_cnt(ovf_cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (run && rst_n) begin
         chk("in_ready", in_ready, mq.size() < 2);
         chk("wb_valid", wb_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("wb_addr", wb_addr, mq[0][5:3]);
            chk("wb_data", wb_data, mq[0][2:0]);
         end
         chk("flags", flags, m_flags);
         chk("ovf_cnt", ovf_cnt, sat(m_ovf, 255));
         chk("ovf_cnt2", ovf_cnt2, sat(m_ovf, 3));
      end
   end

   task automatic idle();
      in_valid = 1'b0; flag_clr = 1'b0; in_wb_en = 1'b0;
      in_op = '0; in_resu = '0; in_o = 0; in_c = 0; in_s = 0; in_z = 0;
      in_wb_addr = '0;
   endtask

   task automatic op(input logic [4:0] opc, input logic [2:0] resu, input logic [3:0] f,
                     input logic wbe, input logic [2:0] addr);
      in_valid = 1'b1; in_op = opc; in_resu = resu;
      {in_o, in_c, in_s, in_z} = f;
      in_wb_en = wbe; in_wb_addr = addr;
   endtask

   // Advance one clock and apply the same edge to the model.
   task automatic tick();
      bit acc, pop;
      @(posedge clk);
      if (rst_n) begin
         acc = in_valid && (mq.size() < 2);
         pop = (mq.size() > 0) && wb_ready;
         if (pop) void'(mq.pop_front());
         if (acc && in_wb_en) mq.push_back({in_wb_addr, in_resu});
         if (acc && in_op[4:3] == 2'b00)      m_flags = {in_o, in_c, in_s, in_z};
         else if (acc && in_op[4:3] == 2'b01) m_flags = {1'b0, in_c, in_s, in_z};
         else if (flag_clr)                   m_flags = 4'b0000;
         if (acc && in_o) m_ovf++;
      end
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_flags = 4'b0000;
      m_ovf   = 0;
   endtask

   initial begin
      int exp2 [4] = '{1, 2, 3, 3};
      idle();
      wb_ready = 1'b1;
      model_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_ovf", ovf_cnt, 8'd0);
      #11 rst_n = 1'b1;
      run = 1'b1;
      tick();

      // 001+111 = 000, carry out, zero
      op(5'b00000, 3'b000, 4'b0101, 1'b1, 3'd3);
      tick(); idle();
      chk("add1_flags", flags, 4'b0101);
      chk("add1_wb_valid", wb_valid, 1'b1);
      chk("add1_wb_addr", wb_addr, 3'd3);
      chk("add1_wb_data", wb_data, 3'b000);
      tick();

      // 010+011 = 101 overflows; then a move with O=1 leaves flags alone
      op(5'b00000, 3'b101, 4'b1010, 1'b0, 3'd0);
      tick();
      chk("add2_flags", flags, 4'b1010);
      chk("add2_ovf", ovf_cnt, 8'd1);
      op(5'b10000, 3'b111, 4'b1111, 1'b0, 3'd0);
      tick(); idle();
      chk("mov_flags", flags, 4'b1010);
      chk("mov_ovf", ovf_cnt, 8'd2);

      // Fill the buffer while the register file stalls
      wb_ready = 1'b0;
      op(5'b01000, 3'b001, 4'b1100, 1'b1, 3'd1);   // shift: O forced to 0
      tick();
      chk("shift_flags", flags, 4'b0100);
      op(5'b11000, 3'b010, 4'b0000, 1'b1, 3'd2);
      tick();
      chk("full_in_ready", in_ready, 1'b0);
      op(5'b00000, 3'b100, 4'b0010, 1'b1, 3'd4);   // held upstream
      tick();
      chk("held_in_ready", in_ready, 1'b0);
      chk("held_head", wb_data, 3'b001);
      chk("held_flags", flags, 4'b0100);
      wb_ready = 1'b1;
      tick();
      chk("drain1_data", wb_data, 3'b010);
      chk("drain1_addr", wb_addr, 3'd2);
      tick(); idle();                               // push and pop together
      chk("drain2_data", wb_data, 3'b100);
      chk("drain2_flags", flags, 4'b0010);
      tick();
      chk("empty_wb_valid", wb_valid, 1'b0);

      // flag_clr against a concurrent arithmetic update, then alone
      op(5'b00000, 3'b000, 4'b1001, 1'b0, 3'd0);
      flag_clr = 1'b1;
      tick(); idle();
      chk("clr_upd_flags", flags, 4'b1001);
      flag_clr = 1'b1;
      tick(); idle();
      chk("clr_flags", flags, 4'b0000);
      op(5'b00000, 3'b000, 4'b0110, 1'b0, 3'd0);
      tick();
      op(5'b10000, 3'b000, 4'b0000, 1'b0, 3'd0);
      flag_clr = 1'b1;
      tick(); idle();
      chk("clr_mov_flags", flags, 4'b0000);

      // Reset with a full buffer and all flags set
      wb_ready = 1'b0;
      op(5'b00000, 3'b011, 4'b1111, 1'b1, 3'd5);
      tick();
      op(5'b00000, 3'b110, 4'b1111, 1'b1, 3'd6);
      tick(); idle();
      chk("prerst_flags", flags, 4'b1111);
      chk("prerst_in_ready", in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_wb_valid", wb_valid, 1'b0);
      chk("mrst_flags", flags, 4'b0000);
      chk("mrst_ovf", ovf_cnt, 8'd0);
      chk("mrst_in_ready", in_ready, 1'b1);
      chk("mrst_ovf2", ovf_cnt2, 2'd0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      wb_ready = 1'b1;
      tick();

      // Saturation of the 2-bit counter
      for (int i = 0; i < 4; i++) begin
         op(5'b10000, 3'b000, 4'b1000, 1'b0, 3'd0);
         tick();
         chk("sat_ovf2", ovf_cnt2, exp2[i]);
         chk("sat_ovf8", ovf_cnt, i + 1);
      end
      idle();
      tick();
      tick();

      run = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
